// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags and N combinational read ports.
// Optional same-cycle write-back forwarding on reads: define RENAME_RF_BYPASS_EN.
module rename_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_CNT  = 32,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         iss_en,
    input  logic [$clog2(REG_CNT)-1:0]   iss_rd,
    input  logic [TAG_W-1:0]             iss_tag,
    input  logic                         wb_en,
    input  logic [$clog2(REG_CNT)-1:0]   wb_rd,
    input  logic [TAG_W-1:0]             wb_tag,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*$clog2(REG_CNT)-1:0] rd_name,
    output logic [RD_PORTS-1:0]          rd_busy,
    output logic [RD_PORTS*TAG_W-1:0]    rd_tag,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data
);

    localparam int unsigned REG_W = $clog2(REG_CNT);

    logic [DATA_W-1:0]  data_q [REG_CNT];
    logic [TAG_W-1:0]   tag_q  [REG_CNT];
    logic [REG_CNT-1:0] busy_q;

    logic iss_act;
    logic wb_act;
    logic wb_match;

    // r0 is hardwired: strobes naming it never touch state
    assign iss_act  = iss_en && (iss_rd != '0) && !flush;
    assign wb_act   = wb_en && (wb_rd != '0);
    assign wb_match = busy_q[wb_rd] && (tag_q[wb_rd] == wb_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < int'(REG_CNT); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            if (wb_act) begin
                data_q[wb_rd] <= wb_data;
            end
            if (flush) begin
                busy_q <= '0;
            end else if (iss_act) begin
                busy_q[iss_rd] <= 1'b1;
                tag_q[iss_rd]  <= iss_tag;
            end
            // a same-cycle issue to the same register wins over the release
            if (!flush && wb_act && wb_match && !(iss_act && (iss_rd == wb_rd))) begin
                busy_q[wb_rd] <= 1'b0;
            end
        end
    end

    logic [REG_W-1:0] idx;

    always_comb begin
        rd_busy = '0;
        rd_tag  = '0;
        rd_data = '0;
        idx     = '0;
        for (int p = 0; p < int'(RD_PORTS); p++) begin
            idx = rd_name[p*REG_W +: REG_W];
            if (rd_en[p] && (idx != '0)) begin
                rd_busy[p]                   = busy_q[idx];
                rd_tag[p*TAG_W +: TAG_W]     = tag_q[idx];
                rd_data[p*DATA_W +: DATA_W]  = data_q[idx];
`ifdef RENAME_RF_BYPASS_EN
                if (wb_en && (wb_rd == idx) && wb_match) begin
                    rd_busy[p]                  = 1'b0;
                    rd_data[p*DATA_W +: DATA_W] = wb_data;
                end
`endif
            end
        end
    end

endmodule
